// File: rtl/dist_acc_pipe.sv
// Pipelined Manhattan-distance accumulator for the annealing placer: sums per-edge
// distances for the pre-swap (A) and post-swap (B) placements and reports the delta per group.
module dist_acc_pipe #(
    parameter int COORD_W = 4,
    parameter int GRID    = 9,
    parameter int ACC_W   = 12,
    parameter int CNT_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [2*COORD_W-1:0]   opa0,
    input  logic [2*COORD_W-1:0]   opa1,
    input  logic                   opav,
    input  logic [2*COORD_W-1:0]   opb0,
    input  logic [2*COORD_W-1:0]   opb1,
    input  logic                   opbv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       da_sum,
    output logic [ACC_W-1:0]       db_sum,
    output logic [ACC_W:0]         delta,
    output logic                   better,
    output logic [CNT_W-1:0]       beat_cnt,
    output logic                   range_err,
    output logic                   sat
);

    localparam int                 OP_W    = 2 * COORD_W;
    localparam int                 DIST_W  = COORD_W + 1;
    localparam logic [COORD_W:0]   GRID_C  = (COORD_W + 1)'(GRID);
    localparam logic [ACC_W-1:0]   ACC_MAX = '1;
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    function automatic logic off_grid(input logic [OP_W-1:0] op);
        return ({1'b0, op[COORD_W-1:0]} >= GRID_C) || ({1'b0, op[OP_W-1:COORD_W]} >= GRID_C);
    endfunction

    // One enable for the whole pipe: a held result freezes every stage.
    logic en;
    logic accept;
    assign en       = !out_valid || out_ready;
    assign in_ready = en && rst_n;
    assign accept   = in_valid && in_ready;

    logic               s1_valid, s1_last;
    logic [COORD_W-1:0] s1_dxa, s1_dya, s1_dxb, s1_dyb;
    logic               s1_va, s1_vb, s1_rfa, s1_rfb;

    // NOTE: sequential state uses non-blocking assignments only, so every stage samples
    // the previous stage's value from before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_dxa   <= '0;
            s1_dya   <= '0;
            s1_dxb   <= '0;
            s1_dyb   <= '0;
            s1_va    <= 1'b0;
            s1_vb    <= 1'b0;
            s1_rfa   <= 1'b0;
            s1_rfb   <= 1'b0;
        end else if (en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_last <= in_last;
                s1_dxa  <= abs_diff(opa0[COORD_W-1:0], opa1[COORD_W-1:0]);
                s1_dya  <= abs_diff(opa0[OP_W-1:COORD_W], opa1[OP_W-1:COORD_W]);
                s1_dxb  <= abs_diff(opb0[COORD_W-1:0], opb1[COORD_W-1:0]);
                s1_dyb  <= abs_diff(opb0[OP_W-1:COORD_W], opb1[OP_W-1:COORD_W]);
                s1_va   <= opav;
                s1_vb   <= opbv;
                s1_rfa  <= opav && (off_grid(opa0) || off_grid(opa1));
                s1_rfb  <= opbv && (off_grid(opb0) || off_grid(opb1));
            end
        end
    end

    logic              s2_valid, s2_last, s2_rf;
    logic [DIST_W-1:0] s2_da, s2_db;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_rf    <= 1'b0;
            s2_da    <= '0;
            s2_db    <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_rf    <= s1_valid && (s1_rfa || s1_rfb);
            s2_da    <= (s1_va && !s1_rfa) ? {1'b0, s1_dxa} + {1'b0, s1_dya} : '0;
            s2_db    <= (s1_vb && !s1_rfb) ? {1'b0, s1_dxb} + {1'b0, s1_dyb} : '0;
        end
    end

    logic [ACC_W-1:0] acc_a, acc_b;
    logic [CNT_W-1:0] cnt;
    logic             rerr_acc, sat_acc;

    logic [ACC_W:0]   sum_a, sum_b;
    logic [ACC_W-1:0] next_a, next_b;
    logic [CNT_W-1:0] next_cnt;
    logic             next_rerr, next_sat;

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        sum_a     = {1'b0, acc_a} + (ACC_W + 1)'(s2_da);
        sum_b     = {1'b0, acc_b} + (ACC_W + 1)'(s2_db);
        next_a    = sum_a[ACC_W] ? ACC_MAX : sum_a[ACC_W-1:0];
        next_b    = sum_b[ACC_W] ? ACC_MAX : sum_b[ACC_W-1:0];
        next_cnt  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        next_rerr = rerr_acc || s2_rf;
        next_sat  = sat_acc || sum_a[ACC_W] || sum_b[ACC_W];
    end

    // NOTE: result registers are reset too, so every output reads 0 while rst_n is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_a     <= '0;
            acc_b     <= '0;
            cnt       <= '0;
            rerr_acc  <= 1'b0;
            sat_acc   <= 1'b0;
            out_valid <= 1'b0;
            da_sum    <= '0;
            db_sum    <= '0;
            delta     <= '0;
            better    <= 1'b0;
            beat_cnt  <= '0;
            range_err <= 1'b0;
            sat       <= 1'b0;
        end else if (en) begin
            out_valid <= 1'b0;
            if (s2_valid) begin
                if (s2_last) begin
                    out_valid <= 1'b1;
                    da_sum    <= next_a;
                    db_sum    <= next_b;
                    delta     <= {1'b0, next_b} - {1'b0, next_a};
                    better    <= next_b < next_a;
                    beat_cnt  <= next_cnt;
                    range_err <= next_rerr;
                    sat       <= next_sat;
                    acc_a     <= '0;
                    acc_b     <= '0;
                    cnt       <= '0;
                    rerr_acc  <= 1'b0;
                    sat_acc   <= 1'b0;
                end else begin
                    acc_a     <= next_a;
                    acc_b     <= next_b;
                    cnt       <= next_cnt;
                    rerr_acc  <= next_rerr;
                    sat_acc   <= next_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_dist_acc_pipe.sv
// Scoreboard bench for dist_acc_pipe: a default instance and an ACC_W=5 instance share
// stimulus; expected group results are queued at issue time and popped by output monitors.
module tb_dist_acc_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_last, opav, opbv, out_ready;
    logic [7:0] opa0, opa1, opb0, opb1;

    logic        in_ready, out_valid, better, range_err, sat;
    logic [11:0] da_sum, db_sum;
    logic [12:0] delta;
    logic [4:0]  beat_cnt;

    logic       in_ready5, out_valid5, better5, range_err5, sat5;
    logic [4:0] da_sum5, db_sum5;
    logic [5:0] delta5;
    logic [4:0] beat_cnt5;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int da;
        int db;
        int delta;
        int better;
        int cnt;
        int rerr;
        int sat;
    } exp_t;

    exp_t q12[$];
    exp_t q5[$];

    always #5 clk = ~clk;

    dist_acc_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .opa0(opa0), .opa1(opa1), .opav(opav), .opb0(opb0), .opb1(opb1), .opbv(opbv),
        .out_valid(out_valid), .out_ready(out_ready), .da_sum(da_sum), .db_sum(db_sum),
        .delta(delta), .better(better), .beat_cnt(beat_cnt), .range_err(range_err), .sat(sat)
    );

    dist_acc_pipe #(.ACC_W(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready5), .in_last(in_last),
        .opa0(opa0), .opa1(opa1), .opav(opav), .opb0(opb0), .opb1(opb1), .opbv(opbv),
        .out_valid(out_valid5), .out_ready(out_ready), .da_sum(da_sum5), .db_sum(db_sum5),
        .delta(delta5), .better(better5), .beat_cnt(beat_cnt5), .range_err(range_err5), .sat(sat5)
    );

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(int da, int db, int dl, int bt, int cn, int re, int st);
        exp_t e;
        e.da = da; e.db = db; e.delta = dl; e.better = bt;
        e.cnt = cn; e.rerr = re; e.sat = st;
        return e;
    endfunction

    task automatic push2(input exp_t e12, input exp_t e5);
        q12.push_back(e12);
        q5.push_back(e5);
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat's accepting edge.
    task automatic send_beat(input logic [7:0] a0, input logic [7:0] a1, input logic av,
                             input logic [7:0] b0, input logic [7:0] b1, input logic bv,
                             input logic last);
        int waited = 0;
        in_valid = 1'b1;
        in_last  = last;
        opa0 = a0; opa1 = a1; opav = av;
        opb0 = b0; opb1 = b1; opbv = bv;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q12.size() != 0 || q5.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q12.size() != 0 || q5.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q12.size() + q5.size());
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid && out_ready) begin
            if (q12.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got da_sum=%0d expected no result", da_sum);
            end else begin
                exp_t e;
                e = q12.pop_front();
                check("da_sum", da_sum, e.da);
                check("db_sum", db_sum, e.db);
                check("delta", $signed(delta), e.delta);
                check("better", better, e.better);
                check("beat_cnt", beat_cnt, e.cnt);
                check("range_err", range_err, e.rerr);
                check("sat", sat, e.sat);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid5 && out_ready) begin
            if (q5.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result5: got da_sum=%0d expected no result", da_sum5);
            end else begin
                exp_t e;
                e = q5.pop_front();
                check("da_sum5", da_sum5, e.da);
                check("db_sum5", db_sum5, e.db);
                check("delta5", $signed(delta5), e.delta);
                check("better5", better5, e.better);
                check("beat_cnt5", beat_cnt5, e.cnt);
                check("range_err5", range_err5, e.rerr);
                check("sat5", sat5, e.sat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        opa0 = '0; opa1 = '0; opav = 1'b0; opb0 = '0; opb1 = '0; opbv = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_in_ready5", in_ready5, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_da_sum", da_sum, 0);
        check("rst_db_sum", db_sum, 0);
        check("rst_delta", delta, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_flags", {better, range_err, sat}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Single beat with latency check.
        push2(mk(16, 4, -12, 1, 1, 0, 0), mk(16, 4, -12, 1, 1, 0, 0));
        send_beat(8'h00, 8'h88, 1, 8'h12, 8'h34, 1, 1);
        @(negedge clk);
        check("lat_cycle1", out_valid, 0);
        @(negedge clk);
        check("lat_cycle2", out_valid, 0);
        @(negedge clk);
        check("lat_cycle3", out_valid, 1);
        @(posedge clk);
        #1;

        // Three-beat group, B absent on the last beat.
        push2(mk(14, 1, -13, 1, 3, 0, 0), mk(14, 1, -13, 1, 3, 0, 0));
        send_beat(8'h00, 8'h11, 1, 8'h00, 8'h01, 1, 0);
        send_beat(8'h22, 8'h20, 1, 8'h33, 8'h33, 1, 0);
        send_beat(8'h05, 8'h50, 1, 8'h00, 8'h88, 0, 1);
        drain();

        // Backpressure: result held for 5 cycles while the next group waits in the pipe.
        out_ready = 1'b0;
        push2(mk(6, 0, -6, 1, 1, 0, 0), mk(6, 0, -6, 1, 1, 0, 0));
        push2(mk(4, 13, 9, 0, 2, 0, 0), mk(4, 13, 9, 0, 2, 0, 0));
        send_beat(8'h11, 8'h44, 1, 8'h00, 8'h00, 1, 1);
        send_beat(8'h13, 8'h31, 1, 8'h00, 8'h23, 1, 0);
        send_beat(8'h00, 8'h00, 1, 8'h44, 8'h00, 1, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_da_sum", da_sum, 6);
            check("hold_delta", $signed(delta), -6);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Off-grid coordinate, then a clean group with an absent off-grid B channel.
        push2(mk(0, 2, 2, 0, 1, 1, 0), mk(0, 2, 2, 0, 1, 1, 0));
        send_beat(8'h09, 8'h00, 1, 8'h00, 8'h02, 1, 1);
        push2(mk(2, 0, -2, 1, 1, 0, 0), mk(2, 0, -2, 1, 1, 0, 0));
        send_beat(8'h01, 8'h10, 1, 8'hFF, 8'h00, 0, 1);

        // Saturation only in the narrow instance.
        push2(mk(48, 3, -45, 1, 3, 0, 0), mk(31, 3, -28, 1, 3, 0, 1));
        for (int i = 0; i < 3; i++)
            send_beat(8'h00, 8'h88, 1, 8'h00, 8'h01, 1, logic'(i == 2));

        // 33 beats with bubbles: beat counter saturates at 31.
        push2(mk(33, 0, -33, 1, 31, 0, 0), mk(31, 0, -31, 1, 31, 0, 1));
        for (int i = 0; i < 33; i++) begin
            send_beat(8'h00, 8'h01, 1, 8'h00, 8'h00, 0, logic'(i == 32));
            if (i % 8 == 7) begin
                @(posedge clk);
                #1;
            end
        end

        // Last beat with both channels absent still closes the group.
        push2(mk(3, 0, -3, 1, 2, 0, 0), mk(3, 0, -3, 1, 2, 0, 0));
        send_beat(8'h00, 8'h03, 1, 8'h00, 8'h00, 0, 0);
        send_beat(8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1);
        drain();

        // Reset mid-group discards the partial group.
        send_beat(8'h00, 8'h88, 1, 8'h00, 8'h00, 1, 0);
        send_beat(8'h00, 8'h88, 1, 8'h00, 8'h00, 1, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        push2(mk(3, 0, -3, 1, 1, 0, 0), mk(3, 0, -3, 1, 1, 0, 0));
        send_beat(8'h00, 8'h12, 1, 8'h00, 8'h00, 1, 1);
        drain();
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("idle_out_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
